cacheline_adapter: RTL

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: splits line-wide cache reads/writes into BEATS-beat memory bursts.
// Optional feature: define CLA_ADDR_ALIGN_EN to clear the line-offset bits of address_o.
module cacheline_adapter #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int BEATS  = LINE_W / BURST_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [31:0]         addr_q, addr_d;
   logic [LINE_W-1:0]   wline_q, wline_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [31:0]         addr_out;
   logic                last_beat;

   assign last_beat = (beat_q == LAST_BEAT);
   assign line_o    = line_q;

`ifdef CLA_ADDR_ALIGN_EN
   localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);
   assign addr_out = addr_q & ~OFF_MASK;
`else
   assign addr_out = addr_q;
`endif

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         line_q  <= line_d;
      end
   end

   // Next-state logic; write wins when both requests are high
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (write_i)     state_d = WR_BURST;
            else if (read_i) state_d = RD_BURST;
         end
         RD_BURST, WR_BURST: begin
            if (resp_i && last_beat) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: request capture, beat counting, fill-line assembly
   always_comb begin
      beat_d  = beat_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      line_d  = line_q;
      case (state_q)
         IDLE: begin
            if (read_i || write_i) begin
               addr_d = address_i;
               beat_d = '0;
               if (write_i) wline_d = line_i;
            end
         end
         RD_BURST: begin
            if (resp_i) begin
               beat_d = last_beat ? '0 : beat_q + 1'b1;
               for (int k = 0; k < BEATS; k++) begin
                  if (beat_q == BEAT_W'(k)) line_d[k*BURST_W +: BURST_W] = burst_i;
               end
            end
         end
         WR_BURST: begin
            if (resp_i) beat_d = last_beat ? '0 : beat_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs decoded from the registered state only
   always_comb begin
      read_o    = (state_q == RD_BURST);
      write_o   = (state_q == WR_BURST);
      resp_o    = (state_q == DONE);
      address_o = (read_o || write_o) ? addr_out : 32'd0;
      burst_o   = '0;
      if (state_q == WR_BURST) begin
         for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) burst_o = wline_q[k*BURST_W +: BURST_W];
         end
      end
   end

endmodule
